// File: rtl/sqrt32_sched.sv
// Round-robin front end sharing one combinational sqrt32 among NREQ requesters.
// Latency: accept to o_rsp_valid = SETTLE+2 cycles; one result per SETTLE+3 cycles at best.
// Backpressure: o_rsp_valid holds until i_rsp_ready; no new operand is granted meanwhile.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_req_valid      per-requester operand valid (NREQ bits)
//   i_req_data       operand i at [32*i+31:32*i]
//   o_req_ready      one-hot grant, combinational, only in IDLE
//   o_sq_p           registered operand driven into sqrt32
//   i_sq_u           root returned by sqrt32
//   o_rsp_valid/i_rsp_ready/o_rsp_id/o_rsp_root   result handshake, id tag and root
//   o_busy           high whenever the scheduler is not IDLE
module sqrt32_sched #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [32*NREQ-1:0]   i_req_data,
  output logic [NREQ-1:0]      o_req_ready,
  output logic [31:0]          o_sq_p,
  input  logic [15:0]          i_sq_u,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [15:0]          o_rsp_root,
  output logic                 o_busy
);

  localparam int CW = $clog2(SETTLE) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_tag;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_sq_p;
  logic [IDW-1:0]  r_rsp_id;
  logic [15:0]     r_rsp_root;

  logic            w_found_hi;
  logic [IDW-1:0]  w_gnt_hi;
  logic [IDW-1:0]  w_gnt_lo;
  logic [IDW-1:0]  w_gnt;
  logic            w_any;
  logic            w_accept;
  logic            w_settled;

  // Round-robin search split into two priority scans: the lowest valid index
  // at or above r_rr_ptr wins, otherwise the lowest valid index overall.
  // Scanning downwards lets the last hit be the lowest index.
  always_comb begin
    w_found_hi = 1'b0;
    w_gnt_hi   = '0;
    w_gnt_lo   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (i_req_valid[j]) begin
        w_gnt_lo = IDW'(j);
        if (IDW'(j) >= r_rr_ptr) begin
          w_found_hi = 1'b1;
          w_gnt_hi   = IDW'(j);
        end
      end
    end
  end

  assign w_gnt     = w_found_hi ? w_gnt_hi : w_gnt_lo;
  assign w_any     = |i_req_valid;
  assign w_settled = (r_cnt == CW'(SETTLE - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)       w_next = S_WAIT;
      S_WAIT:  if (w_settled)   w_next = S_CAPT;
      S_CAPT:                   w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_req_ready = '0;
    w_accept    = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_rsp_valid = (r_state == S_RESP);
    if (r_state == S_IDLE && w_any) begin
      o_req_ready[w_gnt] = 1'b1;
      w_accept           = 1'b1;
    end
  end

  // Datapath: operand hold, settle counter, result capture.
  // o_sq_p is deliberately left at the last operand after capture so the
  // sqrt32 inputs only toggle on a new accept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr   <= '0;
      r_tag      <= '0;
      r_cnt      <= '0;
      r_sq_p     <= '0;
      r_rsp_id   <= '0;
      r_rsp_root <= '0;
    end else begin
      if (w_accept) begin
        r_sq_p   <= i_req_data[32*w_gnt +: 32];
        r_tag    <= w_gnt;
        r_rr_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
        r_cnt    <= '0;
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_CAPT) begin
        r_rsp_root <= i_sq_u;
        r_rsp_id   <= r_tag;
      end
    end
  end

  assign o_sq_p     = r_sq_p;
  assign o_rsp_id   = r_rsp_id;
  assign o_rsp_root = r_rsp_root;

endmodule

// File: tb/tb_sqrt32_sched.sv
// Bench for sqrt32_sched with a behavioural sqrt32 on o_sq_p/i_sq_u.
// Latency: checks accept-to-valid of SETTLE+2 cycles on every operation.
// Backpressure: holds i_rsp_ready low to check result stability and grant blocking.
module tb_sqrt32_sched;

  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int SETTLE = 32;
  localparam int LAT    = SETTLE + 2;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic [NREQ-1:0]     i_req_valid;
  logic [32*NREQ-1:0]  i_req_data;
  logic [NREQ-1:0]     o_req_ready;
  logic [31:0]         o_sq_p;
  logic [15:0]         i_sq_u;
  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [IDW-1:0]      o_rsp_id;
  logic [15:0]         o_rsp_root;
  logic                o_busy;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  sqrt32_sched #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_sq_p      (o_sq_p),
    .i_sq_u      (i_sq_u),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_root  (o_rsp_root),
    .o_busy      (o_busy)
  );

  // Stand-in for the gate-level sqrt32: digit-by-digit restoring root.
  function automatic logic [15:0] sqrt_digit(input logic [31:0] p);
    logic [33:0] rem;
    logic [33:0] trial;
    logic [15:0] root;
    rem  = '0;
    root = '0;
    for (int i = 15; i >= 0; i--) begin
      rem   = {rem[31:0], p[2*i+1 -: 2]};
      trial = {16'd0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[14:0], 1'b1};
      end else begin
        root = {root[14:0], 1'b0};
      end
    end
    return root;
  endfunction

  always_comb i_sq_u = sqrt_digit(o_sq_p);

  // Independent reference: binary search for the largest r with r*r <= p.
  function automatic logic [15:0] sqrt_ref(input logic [31:0] p);
    longint lo = 0;
    longint hi = 65535;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(p)) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called with inputs already set, between edges. Returns just after the
  // accepting edge (at the following negedge).
  task automatic grant(input int id, input string nm, output int waited);
    int n = 0;
    #1;
    while (o_req_ready == '0 && n < 100) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    chk({nm, " grant"}, 32'(o_req_ready), 32'(1 << id));
    waited = n;
    @(negedge i_clk);
  endtask

  // Called at the negedge right after the accept edge.
  task automatic wait_rsp(input logic [31:0] exp_p, input int id,
                          input logic [15:0] root, input string nm);
    int n = 1;
    bit stray = 1'b0;
    #1;
    chk({nm, " sq_p"}, o_sq_p, exp_p);
    while (!o_rsp_valid && n < 100) begin
      if (o_req_ready != '0) stray = 1'b1;
      @(negedge i_clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(LAT));
    chk({nm, " root"}, 32'(o_rsp_root), 32'(root));
    chk({nm, " id"}, 32'(o_rsp_id), 32'(id));
    chk({nm, " grant while busy"}, 32'(stray), 32'd0);
  endtask

  task automatic handshake(input string nm);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    #1;
    chk({nm, " idle after hs"}, 32'(o_busy), 32'd0);
    chk({nm, " valid after hs"}, 32'(o_rsp_valid), 32'd0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [15:0] root;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w;
    bit stab;
    bit seen;
    logic [31:0] p;
    int   t3_id[5];
    logic [31:0] t3_dat[5];
    logic [15:0] t3_root[5];

    vecs[0] = '{id: 0, data: 32'd4,          root: 16'd2};
    vecs[1] = '{id: 0, data: 32'd64,         root: 16'd8};
    vecs[2] = '{id: 1, data: 32'hFFFF_FFFF,  root: 16'hFFFF};
    vecs[3] = '{id: 2, data: 32'd0,          root: 16'd0};
    vecs[4] = '{id: 3, data: 32'h4000_0000,  root: 16'h8000};

    t3_id   = '{0, 1, 2, 3, 0};
    t3_dat  = '{32'd9, 32'd16, 32'd25, 32'd36, 32'd9};
    t3_root = '{16'd3, 16'd4, 16'd5, 16'd6, 16'd3};

    i_reset     = 1'b1;
    i_req_valid = '0;
    i_req_data  = '0;
    i_rsp_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("reset busy",     32'(o_busy),      32'd0);
    chk("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset sq_p",     o_sq_p,           32'd0);
    chk("reset rsp_id",   32'(o_rsp_id),    32'd0);
    chk("reset rsp_root", 32'(o_rsp_root),  32'd0);
    chk("reset req_ready", 32'(o_req_ready), 32'd0);
    i_reset = 1'b0;

    // Single operations, one requester at a time
    for (int k = 0; k < 5; k++) begin
      i_req_valid = NREQ'(1 << vecs[k].id);
      i_req_data[32*vecs[k].id +: 32] = vecs[k].data;
      grant(vecs[k].id, $sformatf("vec%0d", k), w);
      chk($sformatf("vec%0d same-cycle grant", k), 32'(w), 32'd0);
      i_req_valid = '0;
      wait_rsp(vecs[k].data, vecs[k].id, vecs[k].root, $sformatf("vec%0d", k));
      handshake($sformatf("vec%0d", k));
    end

    // All four requesting, consumer always ready: strict rotation
    i_req_data  = {32'd36, 32'd25, 32'd16, 32'd9};
    i_req_valid = 4'b1111;
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      grant(t3_id[k], $sformatf("rr%0d", k), w);
      if (k == 4) i_req_valid = '0;
      wait_rsp(t3_dat[k], t3_id[k], t3_root[k], $sformatf("rr%0d", k));
    end
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    #1;
    chk("rr idle at end", 32'(o_busy), 32'd0);

    // Backpressure: result held 50 cycles with requests pending
    i_req_valid = 4'b1111;
    grant(1, "bp", w);
    wait_rsp(32'd16, 1, 16'd4, "bp");
    stab = 1'b0;
    repeat (50) begin
      @(negedge i_clk);
      #1;
      if (!o_rsp_valid || o_rsp_root != 16'd4 || o_rsp_id != 2'd1 ||
          o_req_ready != '0 || !o_busy) stab = 1'b1;
    end
    chk("bp hold stable", 32'(stab), 32'd0);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    #1;
    chk("bp idle after hs", 32'(o_busy), 32'd0);
    chk("bp rr_ptr advanced", 32'(o_req_ready), 32'b0100);
    grant(2, "bp2", w);
    i_req_valid = '0;
    wait_rsp(32'd25, 2, 16'd5, "bp2");
    handshake("bp2");

    // Reset in the middle of WAIT aborts the operation
    i_req_data[32*2 +: 32] = 32'd100;
    i_req_valid = 4'b0100;
    grant(2, "abort", w);
    i_req_valid = '0;
    repeat (10) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("abort busy",      32'(o_busy),      32'd0);
    chk("abort rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("abort sq_p",      o_sq_p,           32'd0);
    seen = 1'b0;
    repeat (60) begin
      @(negedge i_clk);
      #1;
      if (o_rsp_valid || o_busy) seen = 1'b1;
    end
    chk("abort no result", 32'(seen), 32'd0);
    // rr_ptr back at 0: requester 1 beats requester 3
    i_req_data[32*1 +: 32] = 32'd49;
    i_req_valid = 4'b1010;
    grant(1, "post-reset", w);
    i_req_valid = '0;
    wait_rsp(32'd49, 1, 16'd7, "post-reset");
    handshake("post-reset");

    // Byte-replicated operand sweep from requester 3
    for (int i = 0; i < 256; i++) begin
      p = {4{8'(i)}};
      i_req_data[32*3 +: 32] = p;
      i_req_valid = 4'b1000;
      grant(3, $sformatf("sweep%0d", i), w);
      i_req_valid = '0;
      wait_rsp(p, 3, sqrt_ref(p), $sformatf("sweep%0d", i));
      handshake($sformatf("sweep%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
